// File: rtl/spi_slv_pkg.sv
// Shared types and helpers for the SPI mode-0 slave.
package spi_slv_pkg;

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        ACTIVE,
        DONE
    } state_e;

    localparam int unsigned SPI_MAXLEN_DEF  = 32;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // Width of bit-count buses: must hold the value SPI_MAXLEN itself.
    function automatic int unsigned cnt_width(input int unsigned maxlen);
        return $clog2(maxlen) + 1;
    endfunction

endpackage

// File: rtl/spi_slv_sync_edge.sv
// Multi-flop input synchroniser with rise/fall pulses derived from the
// last two synchronised samples. All flops reset to the pin's idle level.
module spi_slv_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        IDLE_VAL    = 1'b0
) (
    input  logic clk,
    input  logic sresetn,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            sync_q <= {SYNC_STAGES{IDLE_VAL}};
            prev_q <= IDLE_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slv.sv
// SPI mode-0 slave running entirely in the clk domain. SCLK/SS_N/MOSI are
// synchronised and edge-detected; received frames are delivered as a
// one-cycle rx_valid pulse, and a preloaded word is returned on MISO.
module spi_slv
    import spi_slv_pkg::*;
#(
    parameter int unsigned SPI_MAXLEN  = SPI_MAXLEN_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                       clk,
    input  logic                       sresetn,
    input  logic [SPI_MAXLEN-1:0]      tx_data,
    input  logic [$clog2(SPI_MAXLEN):0] tx_nbits,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic [SPI_MAXLEN-1:0]      rx_data,
    output logic [$clog2(SPI_MAXLEN):0] rx_nbits,
    output logic                       rx_valid,
    output logic                       rx_len_err,
    output logic                       tx_underrun,
    output logic                       busy,
    input  logic                       SCLK,
    input  logic                       MOSI,
    input  logic                       SS_N,
    output logic                       MISO,
    output logic                       MISO_OE
);

    localparam int unsigned CNT_W = cnt_width(SPI_MAXLEN);
    localparam int unsigned ARM_N = SYNC_STAGES + 1;
    localparam int unsigned ARM_W = $clog2(ARM_N + 1);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_slv_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .sresetn(sresetn), .d_i(SCLK),
        .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_slv_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_ss (
        .clk(clk), .sresetn(sresetn), .d_i(SS_N),
        .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
    );
    spi_slv_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .sresetn(sresetn), .d_i(MOSI),
        .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    state_e                 state_q, state_d;
    logic [ARM_W-1:0]       arm_cnt_q;
    logic                   hold_full_q;
    logic [SPI_MAXLEN-1:0]  hold_data_q;
    logic [CNT_W-1:0]       hold_nbits_q;
    logic [SPI_MAXLEN-1:0]  shreg_q, rxsh_q;
    logic [CNT_W-1:0]       cnt_q, exp_n_q;
    logic                   ovf_q;
    logic [SPI_MAXLEN-1:0]  rx_data_q;
    logic [CNT_W-1:0]       rx_nbits_q;
    logic                   rx_valid_q, rx_len_err_q, tx_underrun_q;

    logic start, take, arm_ok;

    assign start  = (state_q == IDLE) && ss_fall;
    assign take   = start && hold_full_q;
    assign arm_ok = (arm_cnt_q == ARM_W'(ARM_N));

    // The holding register is emptied by the frame-start load in the same
    // cycle, so a new word may be accepted while the old one is taken.
    assign tx_ready = ~hold_full_q | take;

    // State register.
    always_ff @(posedge clk) begin
        if (!sresetn) state_q <= ARM;
        else          state_q <= state_d;
    end

    // Next-state and pin-side outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        MISO_OE = 1'b0;
        MISO    = 1'b0;
        case (state_q)
            ARM:    if (arm_ok)  state_d = IDLE;
            IDLE:   if (ss_fall) state_d = ACTIVE;
            ACTIVE: begin
                busy    = 1'b1;
                MISO_OE = 1'b1;
                MISO    = shreg_q[SPI_MAXLEN-1];
                if (ss_rise) state_d = DONE;
            end
            DONE:   state_d = IDLE;
            default: state_d = ARM;
        endcase
    end

    // Synchroniser reset values look like an idle SS_N; leaving ARM waits
    // until SS_N has been high long enough that real pin samples are seen.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            arm_cnt_q <= '0;
        end else if (state_q == ARM) begin
            if (!ss_lvl)      arm_cnt_q <= '0;
            else if (!arm_ok) arm_cnt_q <= arm_cnt_q + ARM_W'(1);
        end
    end

    // TX holding register.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            hold_full_q  <= 1'b0;
            hold_data_q  <= '0;
            hold_nbits_q <= '0;
        end else begin
            if (take) hold_full_q <= 1'b0;
            if (tx_valid && tx_ready) begin
                hold_full_q  <= 1'b1;
                hold_data_q  <= tx_data;
                hold_nbits_q <= tx_nbits;
            end
        end
    end

    // Frame datapath: load at start, shift in on SCLK rise, out on fall.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            shreg_q <= '0;
            rxsh_q  <= '0;
            cnt_q   <= '0;
            exp_n_q <= '0;
            ovf_q   <= 1'b0;
        end else if (start) begin
            shreg_q <= take ? (hold_data_q << (CNT_W'(SPI_MAXLEN) - hold_nbits_q)) : '0;
            exp_n_q <= take ? hold_nbits_q : '0;
            rxsh_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (state_q == ACTIVE) begin
            if (sclk_rise) begin
                rxsh_q <= {rxsh_q[SPI_MAXLEN-2:0], mosi_lvl};
                if (cnt_q == CNT_W'(SPI_MAXLEN)) ovf_q <= 1'b1;
                else                             cnt_q <= cnt_q + CNT_W'(1);
            end
            if (sclk_fall) shreg_q <= shreg_q << 1;
        end
    end

    // Frame delivery and status pulses.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            rx_data_q     <= '0;
            rx_nbits_q    <= '0;
            rx_valid_q    <= 1'b0;
            rx_len_err_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= start && !hold_full_q;
            if (state_q == DONE && cnt_q != '0) begin
                rx_data_q    <= rxsh_q & ({SPI_MAXLEN{1'b1}} >> (CNT_W'(SPI_MAXLEN) - cnt_q));
                rx_nbits_q   <= cnt_q;
                rx_valid_q   <= 1'b1;
                rx_len_err_q <= ovf_q | (cnt_q != exp_n_q);
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_nbits    = rx_nbits_q;
    assign rx_valid    = rx_valid_q;
    assign rx_len_err  = rx_len_err_q;
    assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slv.sv
// Bench for spi_slv: behavioural SPI master plus a frame-level reference
// model of what the slave must return and deliver.
module tb_spi_slv;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        sresetn = 1'b0;
    logic [31:0] tx_data = '0;
    logic [5:0]  tx_nbits = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic [5:0]  rx_nbits;
    logic        rx_valid, rx_len_err, tx_underrun, busy;
    logic        SCLK = 1'b0, MOSI = 1'b0, SS_N = 1'b1;
    logic        MISO, MISO_OE;

    always #5 clk = ~clk;

    spi_slv #(.SPI_MAXLEN(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .sresetn(sresetn),
        .tx_data(tx_data), .tx_nbits(tx_nbits), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_nbits(rx_nbits), .rx_valid(rx_valid), .rx_len_err(rx_len_err),
        .tx_underrun(tx_underrun), .busy(busy),
        .SCLK(SCLK), .MOSI(MOSI), .SS_N(SS_N), .MISO(MISO), .MISO_OE(MISO_OE)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Event monitor
    int          rxv_cnt = 0, und_cnt = 0, pin_bad = 0;
    logic [31:0] last_data;
    logic [5:0]  last_nbits;
    logic        last_err;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rxv_cnt++;
            last_data  = rx_data;
            last_nbits = rx_nbits;
            last_err   = rx_len_err;
        end
        if (tx_underrun === 1'b1) und_cnt++;
        if (MISO_OE !== busy || (busy !== 1'b1 && MISO !== 1'b0)) pin_bad++;
    end

    // Reference model: words accepted but not yet consumed by a frame
    logic [31:0] hq_w[$];
    int          hq_n[$];

    function automatic logic [63:0] exp_miso(input bit present, input logic [31:0] w,
                                            input int nb, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) begin
            bit b = 1'b0;
            if (present && i < nb) b = w[nb-1-i];
            r = {r[62:0], b};
        end
        return r;
    endfunction

    task automatic drive_tx(input logic [31:0] w, input int nb, output bit ok);
        int k = 0;
        tx_data  = w;
        tx_nbits = 6'(nb);
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        ok = (tx_ready === 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic push_tx(input logic [31:0] w, input int nb);
        bit ok;
        drive_tx(w, nb, ok);
        check_eq("tx_hs_preload", 64'(ok), 64'd1);
        hq_w.push_back(w);
        hq_n.push_back(nb);
    endtask

    task automatic xfer(input logic [63:0] mv, input int n, output logic [63:0] cap);
        cap = '0;
        @(negedge clk);
        SS_N = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            MOSI = mv[n-1-i];
            repeat (HALF) @(negedge clk);
            cap  = {cap[62:0], MISO};
            SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
            SCLK = 1'b0;
        end
        MOSI = 1'b0;
        repeat (HALF) @(negedge clk);
        SS_N = 1'b1;
        repeat (3*HALF) @(negedge clk);
    endtask

    // One frame checked against the model; optionally writes a new word
    // concurrently so that it lands in the frame-start load cycle.
    task automatic frame(input logic [63:0] mv, input int n, input bit swap,
                         input logic [31:0] sw, input int snb, input string tg);
        bit          present = (hq_w.size() > 0);
        logic [31:0] w = '0;
        int          nb = 0;
        int          rv0 = rxv_cnt, u0 = und_cnt, pb0 = pin_bad;
        int          nr = (n > 32) ? 32 : n;
        logic [63:0] cap;
        bit          ok = 1'b1;
        if (present) begin
            w  = hq_w.pop_front();
            nb = hq_n.pop_front();
        end
        if (swap) begin
            fork
                xfer(mv, n, cap);
                drive_tx(sw, snb, ok);
            join
            check_eq({tg, ".tx_hs_swap"}, 64'(ok), 64'd1);
            hq_w.push_back(sw);
            hq_n.push_back(snb);
        end else begin
            xfer(mv, n, cap);
        end
        check_eq({tg, ".miso"}, cap, exp_miso(present, w, nb, n));
        check_eq({tg, ".underrun"}, 64'(und_cnt - u0), 64'(!present));
        check_eq({tg, ".nvalid"}, 64'(rxv_cnt - rv0), (n > 0) ? 64'd1 : 64'd0);
        check_eq({tg, ".pins"}, 64'(pin_bad - pb0), 64'd0);
        if (n > 0) begin
            check_eq({tg, ".rx_data"}, 64'(last_data), mv & ((64'd1 << nr) - 64'd1));
            check_eq({tg, ".rx_nbits"}, 64'(last_nbits), 64'(nr));
            check_eq({tg, ".len_err"}, 64'(last_err),
                     64'((n > 32) || (nr != (present ? nb : 0))));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv0, u0, nb_last, n;
        logic [63:0] mv;

        repeat (4) @(negedge clk);
        check_eq("rst.tx_ready", 64'(tx_ready), 64'd1);
        check_eq("rst.rx_data", 64'(rx_data), 64'd0);
        check_eq("rst.rx_nbits", 64'(rx_nbits), 64'd0);
        check_eq("rst.flags", 64'({rx_valid, rx_len_err, tx_underrun, busy, MISO, MISO_OE}), 64'd0);
        sresetn = 1'b1;
        repeat (10) @(negedge clk);

        push_tx(32'hA5, 8);
        frame(64'h3C, 8, 1'b0, '0, 0, "t1");
        push_tx(32'hDEADBEEF, 32);
        frame(64'h12345678, 32, 1'b0, '0, 0, "t2");
        frame(64'h0F, 4, 1'b0, '0, 0, "t3");
        push_tx(32'h5A, 8);
        frame(64'h13, 5, 1'b0, '0, 0, "t4");

        push_tx(32'h81, 8);
        frame(64'hC3, 8, 1'b1, 32'h7E, 8, "t6a");
        check_eq("t6.tx_ready_between", 64'(tx_ready), 64'd0);
        frame(64'h99, 8, 1'b0, '0, 0, "t6b");

        // Reset in the middle of a frame, released with SS_N still low
        push_tx(32'hF00D, 16);
        rv0 = rxv_cnt;
        u0  = und_cnt;
        @(negedge clk);
        SS_N = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                sresetn = 1'b0;
                repeat (4) @(negedge clk);
                sresetn = 1'b1;
            end
            MOSI = i[0];
            repeat (HALF) @(negedge clk);
            SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        SS_N = 1'b1;
        repeat (3*HALF) @(negedge clk);
        hq_w.delete();
        hq_n.delete();
        check_eq("t5.no_valid", 64'(rxv_cnt - rv0), 64'd0);
        check_eq("t5.no_underrun", 64'(und_cnt - u0), 64'd0);
        check_eq("t5.tx_ready", 64'(tx_ready), 64'd1);
        push_tx(32'h0000BEEF, 16);
        frame(64'hCAFE, 16, 1'b0, '0, 0, "t5b");

        nb_last = 8;
        for (int it = 0; it < 30; it++) begin
            int r;
            if (hq_w.size() == 0 && $urandom_range(0, 3) != 0) begin
                nb_last = $urandom_range(1, 32);
                push_tx($urandom, nb_last);
            end
            r = $urandom_range(0, 9);
            if (r < 4)       n = nb_last;
            else if (r < 7)  n = $urandom_range(1, 32);
            else if (r == 7) n = 0;
            else             n = $urandom_range(32, 34);
            mv = {$urandom, $urandom};
            frame(mv, n, 1'b0, '0, 0, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
